// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch request channel between the PC generator and the fetch unit.
// The master presents an address with a valid flag; the slave accepts it with ready.
interface pc_gen_if #(
  parameter int AddrWidth = 32
) ();
  logic                 fetch_valid_o;
  logic                 fetch_ready_i;
  logic [AddrWidth-1:0] fetch_pc_o;

  modport master (
    output fetch_valid_o,
    output fetch_pc_o,
    input  fetch_ready_i
  );

  modport slave (
    input  fetch_valid_o,
    input  fetch_pc_o,
    output fetch_ready_i
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter unit. Issues sequential fetch addresses over a
// valid/ready channel, holds on stalls and applies registered EXE-stage
// redirects with a one-cycle flush pulse. Counts taken redirects (saturating).
// Optional feature macro: PC_MISALIGN_TRAP_EN -- a taken target that breaks the
// fetch alignment is replaced by TrapVector and misalign_o pulses. Without the
// macro the target's low bits are silently cleared.
module pc_gen #(
  parameter int                   AddrWidth    = 32,
  parameter int                   CtrlWidth    = 2,
  parameter logic [AddrWidth-1:0] StartAddress = '0,
  parameter bit                   CompressedEn = 1'b0,
  parameter logic [AddrWidth-1:0] TrapVector   = '0,
  parameter int                   CntWidth     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  pc_gen_if.master             fetch,
  input  logic                 step_i,
  input  logic                 redir_valid_i,
  input  logic [CtrlWidth-1:0] redir_ctrl_i,
  input  logic [AddrWidth-1:0] redir_pc_i,
  input  logic [AddrWidth-1:0] redir_op3_i,
  input  logic [AddrWidth-1:0] redir_exe_out_i,
  output logic                 flush_o,
  output logic                 misalign_o,
  output logic [CntWidth-1:0]  redir_cnt_o
);

  localparam logic [CtrlWidth-1:0] PC_INC  = CtrlWidth'(0);
  localparam logic [CtrlWidth-1:0] PC_SET  = CtrlWidth'(1);
  localparam logic [CtrlWidth-1:0] PC_ADD  = CtrlWidth'(2);
  localparam logic [CtrlWidth-1:0] PC_COND = CtrlWidth'(3);

  // Halfword alignment when compressed instructions are allowed, word otherwise.
  localparam logic [AddrWidth-1:0] AlignMask = CompressedEn ? ~AddrWidth'(1) : ~AddrWidth'(3);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_e;

  function automatic logic [AddrWidth-1:0] step_size(input logic half);
    return (CompressedEn && half) ? AddrWidth'(2) : AddrWidth'(4);
  endfunction

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] pc_q;
  logic [CntWidth-1:0]  cnt_q;

  logic                 redir_vld_p0;
  logic [CtrlWidth-1:0] redir_ctrl_p0;
  logic [AddrWidth-1:0] redir_pc_p0;
  logic [AddrWidth-1:0] redir_op3_p0;
  logic [AddrWidth-1:0] redir_exe_p0;

  logic                 taken;
  logic [AddrWidth-1:0] tgt_raw;
  logic [AddrWidth-1:0] tgt;
  logic                 advance;

  // ---- stage p0: capture the EXE redirect command ----
  // Redirect command register; payload only loads on a valid command.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redir_vld_p0  <= 1'b0;
      redir_ctrl_p0 <= '0;
      redir_pc_p0   <= '0;
      redir_op3_p0  <= '0;
      redir_exe_p0  <= '0;
    end else begin
      redir_vld_p0 <= redir_valid_i;
      if (redir_valid_i) begin
        redir_ctrl_p0 <= redir_ctrl_i;
        redir_pc_p0   <= redir_pc_i;
        redir_op3_p0  <= redir_op3_i;
        redir_exe_p0  <= redir_exe_out_i;
      end
    end
  end

  // ---- stage p1: resolve target from the registered command ----
  // Decode the registered command into a raw target and a taken flag.
  always_comb begin
    tgt_raw = '0;
    taken   = 1'b0;
    case (redir_ctrl_p0)
      PC_SET: begin
        tgt_raw = {redir_exe_p0[AddrWidth-1:1], 1'b0};
        taken   = 1'b1;
      end
      PC_ADD: begin
        tgt_raw = redir_pc_p0 + redir_exe_p0;
        taken   = 1'b1;
      end
      PC_COND: begin
        tgt_raw = redir_pc_p0 + redir_op3_p0;
        taken   = redir_exe_p0[0];
      end
      PC_INC:  ;
      default: ;
    endcase
    taken = taken & redir_vld_p0;
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(tgt_raw & ~AlignMask);
  assign tgt        = misaligned ? TrapVector : tgt_raw;
  assign misalign_o = taken & misaligned;
`else
  logic unused_trap;
  assign unused_trap = ^TrapVector;
  assign tgt         = tgt_raw & AlignMask;
  assign misalign_o  = 1'b0;
`endif

  assign flush_o     = taken;
  assign redir_cnt_o = cnt_q;
  assign fetch.fetch_pc_o = pc_q;

  // Control state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next state and request valid; a flush cycle squashes the request.
  always_comb begin
    state_d             = state_q;
    fetch.fetch_valid_o = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        fetch.fetch_valid_o = ~taken;
        if (stall_i) state_d = STALL;
      end
      STALL: begin
        fetch.fetch_valid_o = ~taken;
        if (!stall_i) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  assign advance = (state_q == RUN) & fetch.fetch_valid_o & fetch.fetch_ready_i & ~stall_i;

  // PC update: taken redirect beats stall, stall beats handshake advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        pc_q <= StartAddress;
    else if (taken)   pc_q <= tgt;
    else if (advance) pc_q <= pc_q + step_size(step_i);
  end

  // Saturating count of taken redirects.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      cnt_q <= '0;
    else if (taken) cnt_q <= sat_inc(cnt_q);
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen. dut0 is word-aligned (StartAddress
// 0x100, TrapVector 0x80); dut1 allows compressed steps with a 2-bit counter
// (StartAddress 0, TrapVector 0x40). Builds with or without PC_MISALIGN_TRAP_EN.
module tb_pc_gen;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_SET  = 2'd1;
  localparam logic [1:0] PC_ADD  = 2'd2;
  localparam logic [1:0] PC_COND = 2'd3;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] SetOddTgt = 32'h80;
  localparam logic        SetOddMis = 1'b1;
  localparam logic [31:0] AddOddTgt = 32'h40;
  localparam logic        AddOddMis = 1'b1;
`else
  localparam logic [31:0] SetOddTgt = 32'h1000;
  localparam logic        SetOddMis = 1'b0;
  localparam logic [31:0] AddOddTgt = 32'h10;
  localparam logic        AddOddMis = 1'b0;
`endif

  typedef struct packed {
    logic        v;
    logic        f;
    logic        m;
    logic [31:0] pc;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic [1:0]  c;
    logic [31:0] pc;
    logic [31:0] op3;
    logic [31:0] exe;
    logic        tk;
    logic [31:0] tgt;
    logic        mis;
  } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, stall0, step0, rv0, flush0, mis0;
  logic [1:0]  rc0;
  logic [31:0] rpc0, rop0, rexe0;
  logic [15:0] cnt0;
  logic        rst1, stall1, step1, rv1, flush1, mis1;
  logic [1:0]  rc1;
  logic [31:0] rpc1, rop1, rexe1;
  logic [1:0]  cnt1;

  pc_gen_if #(.AddrWidth(32)) f0 ();
  pc_gen_if #(.AddrWidth(32)) f1 ();

  pc_gen #(.AddrWidth(32), .CtrlWidth(2), .StartAddress(32'h100), .CompressedEn(1'b0),
           .TrapVector(32'h80), .CntWidth(16)) dut0 (
    .clk_i(clk), .rst_i(rst0), .stall_i(stall0), .fetch(f0), .step_i(step0),
    .redir_valid_i(rv0), .redir_ctrl_i(rc0), .redir_pc_i(rpc0), .redir_op3_i(rop0),
    .redir_exe_out_i(rexe0), .flush_o(flush0), .misalign_o(mis0), .redir_cnt_o(cnt0));

  pc_gen #(.AddrWidth(32), .CtrlWidth(2), .StartAddress(32'h0), .CompressedEn(1'b1),
           .TrapVector(32'h40), .CntWidth(2)) dut1 (
    .clk_i(clk), .rst_i(rst1), .stall_i(stall1), .fetch(f1), .step_i(step1),
    .redir_valid_i(rv1), .redir_ctrl_i(rc1), .redir_pc_i(rpc1), .redir_op3_i(rop1),
    .redir_exe_out_i(rexe1), .flush_o(flush1), .misalign_o(mis1), .redir_cnt_o(cnt1));

  obs_t obs0, obs1;
  assign obs0 = {f0.fetch_valid_o, flush0, mis0, f0.fetch_pc_o, cnt0};
  assign obs1 = {f1.fetch_valid_o, flush1, mis1, f1.fetch_pc_o, 14'd0, cnt1};

  int   checks = 0;
  int   failures = 0;
  obs_t q0[$];
  obs_t q1[$];
  obs_t m0, m1;
  rd_t  rtab[6];

  function automatic string fmt(obs_t o);
    return $sformatf("v=%b flush=%b mis=%b pc=%h cnt=%0d", o.v, o.f, o.m, o.pc, o.cnt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst0 = 1'b1; rst1 = 1'b1;
    stall0 = 0; step0 = 0; rv0 = 0; rc0 = PC_INC; rpc0 = '0; rop0 = '0; rexe0 = '0;
    stall1 = 0; step1 = 0; rv1 = 0; rc1 = PC_INC; rpc1 = '0; rop1 = '0; rexe1 = '0;
    f0.fetch_ready_i = 1'b0; f1.fetch_ready_i = 1'b0;
    m0 = '{v: 1'b0, f: 1'b0, m: 1'b0, pc: 32'h100, cnt: 16'd0};
    m1 = '{v: 1'b0, f: 1'b0, m: 1'b0, pc: 32'h0,   cnt: 16'd0};
    q0.push_back(m0); q1.push_back(m1);
    repeat (2) tick();
    e = q0.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL reset0 got %s want %s", fmt(obs0), fmt(e)); end
    e = q1.pop_front(); checks++;
    if (obs1 !== e) begin failures++; $display("FAIL reset1 got %s want %s", fmt(obs1), fmt(e)); end
    // release: one BOOT cycle with no request even though ready is high
    rst0 = 1'b0; rst1 = 1'b0;
    f0.fetch_ready_i = 1'b1; f1.fetch_ready_i = 1'b1;
    q0.push_back(m0); q1.push_back(m1);
    #1;
    e = q0.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL boot0 got %s want %s", fmt(obs0), fmt(e)); end
    e = q1.pop_front(); checks++;
    if (obs1 !== e) begin failures++; $display("FAIL boot1 got %s want %s", fmt(obs1), fmt(e)); end
    m0.v = 1'b1; m1.v = 1'b1;
    q0.push_back(m0); q1.push_back(m1);
    tick();
    e = q0.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL first0 got %s want %s", fmt(obs0), fmt(e)); end
    e = q1.pop_front(); checks++;
    if (obs1 !== e) begin failures++; $display("FAIL first1 got %s want %s", fmt(obs1), fmt(e)); end
  endtask

  task automatic test_sequential();
    obs_t e;
    f1.fetch_ready_i = 1'b0;
    f0.fetch_ready_i = 1'b1;
    step0 = 1'b1;  // no effect on a word-aligned unit
    for (int i = 0; i < 3; i++) begin
      m0.pc = m0.pc + 32'd4;
      q0.push_back(m0);
      tick();
      e = q0.pop_front(); checks++;
      if (obs0 !== e) begin failures++; $display("FAIL seq%0d got %s want %s", i, fmt(obs0), fmt(e)); end
    end
    step0 = 1'b0;
  endtask

  task automatic test_backpressure();
    obs_t e;
    logic [2:0] tbl [7];  // {ready, stall, expect advance}
    tbl = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b110, 3'b000, 3'b101};
    for (int i = 0; i < 7; i++) begin
      f0.fetch_ready_i = tbl[i][2];
      stall0           = tbl[i][1];
      if (tbl[i][0]) m0.pc = m0.pc + 32'd4;
      q0.push_back(m0);
      tick();
      e = q0.pop_front(); checks++;
      if (obs0 !== e) begin failures++; $display("FAIL bp%0d got %s want %s", i, fmt(obs0), fmt(e)); end
    end
    f0.fetch_ready_i = 1'b0;
    stall0 = 1'b0;
  endtask

  task automatic test_redirect();
    obs_t e;
    rtab[0] = '{c: PC_COND, pc: 32'h200, op3: 32'h40, exe: 32'h1, tk: 1'b1, tgt: 32'h240, mis: 1'b0};
    rtab[1] = '{c: PC_COND, pc: 32'h200, op3: 32'h40, exe: 32'h0, tk: 1'b0, tgt: 32'h0,   mis: 1'b0};
    rtab[2] = '{c: PC_ADD,  pc: 32'h300, op3: 32'h0,  exe: 32'h20, tk: 1'b1, tgt: 32'h320, mis: 1'b0};
    rtab[3] = '{c: PC_ADD,  pc: 32'hFFFF_FFF0, op3: 32'h0, exe: 32'h14, tk: 1'b1, tgt: 32'h4, mis: 1'b0};
    rtab[4] = '{c: PC_SET,  pc: 32'h0, op3: 32'h0, exe: 32'h1003, tk: 1'b1, tgt: SetOddTgt, mis: SetOddMis};
    rtab[5] = '{c: PC_INC,  pc: 32'h700, op3: 32'h8, exe: 32'h1, tk: 1'b0, tgt: 32'h0, mis: 1'b0};
    for (int i = 0; i < 6; i++) begin
      rv0 = 1'b1; rc0 = rtab[i].c; rpc0 = rtab[i].pc; rop0 = rtab[i].op3; rexe0 = rtab[i].exe;
      m0.v = ~rtab[i].tk; m0.f = rtab[i].tk; m0.m = rtab[i].mis;
      q0.push_back(m0);
      tick();
      rv0 = 1'b0;
      e = q0.pop_front(); checks++;
      if (obs0 !== e) begin failures++; $display("FAIL redir%0d_cmd got %s want %s", i, fmt(obs0), fmt(e)); end
      if (rtab[i].tk) begin
        m0.pc  = rtab[i].tgt;
        m0.cnt = m0.cnt + 16'd1;
      end
      m0.v = 1'b1; m0.f = 1'b0; m0.m = 1'b0;
      q0.push_back(m0);
      tick();
      e = q0.pop_front(); checks++;
      if (obs0 !== e) begin failures++; $display("FAIL redir%0d_load got %s want %s", i, fmt(obs0), fmt(e)); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    for (int i = 0; i < 5; i++) begin
      rv0 = (i < 2); rc0 = PC_SET; rexe0 = (i == 0) ? 32'h500 : 32'h600;
      stall0 = (i < 4); f0.fetch_ready_i = (i < 4);
      if (i == 1) begin m0.pc = 32'h500; m0.cnt = m0.cnt + 16'd1; end
      if (i == 2) begin m0.pc = 32'h600; m0.cnt = m0.cnt + 16'd1; end
      m0.v = (i >= 2); m0.f = (i < 2); m0.m = 1'b0;
      q0.push_back(m0);
      tick();
      e = q0.pop_front(); checks++;
      if (obs0 !== e) begin failures++; $display("FAIL b2b%0d got %s want %s", i, fmt(obs0), fmt(e)); end
    end
    rv0 = 1'b0;
  endtask

  task automatic test_compressed();
    obs_t e;
    logic [2:0] steps;
    steps = 3'b101;
    f1.fetch_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step1 = steps[i];
      m1.pc = m1.pc + (steps[i] ? 32'd2 : 32'd4);
      q1.push_back(m1);
      tick();
      e = q1.pop_front(); checks++;
      if (obs1 !== e) begin failures++; $display("FAIL cstep%0d got %s want %s", i, fmt(obs1), fmt(e)); end
    end
    f1.fetch_ready_i = 1'b0; step1 = 1'b0;
    // halfword-misaligned PC_ADD target on the compressed unit
    rv1 = 1'b1; rc1 = PC_ADD; rpc1 = 32'h11; rexe1 = 32'h0;
    m1.v = 1'b0; m1.f = 1'b1; m1.m = AddOddMis;
    q1.push_back(m1);
    tick();
    rv1 = 1'b0;
    e = q1.pop_front(); checks++;
    if (obs1 !== e) begin failures++; $display("FAIL codd_cmd got %s want %s", fmt(obs1), fmt(e)); end
    m1.v = 1'b1; m1.f = 1'b0; m1.m = 1'b0; m1.pc = AddOddTgt; m1.cnt = 16'd1;
    q1.push_back(m1);
    tick();
    e = q1.pop_front(); checks++;
    if (obs1 !== e) begin failures++; $display("FAIL codd_load got %s want %s", fmt(obs1), fmt(e)); end
  endtask

  task automatic test_cnt_sat();
    obs_t e;
    for (int k = 0; k < 4; k++) begin
      rv1 = 1'b1; rc1 = PC_SET; rexe1 = 32'h20 * (k + 1);
      m1.v = 1'b0; m1.f = 1'b1;
      q1.push_back(m1);
      tick();
      rv1 = 1'b0;
      e = q1.pop_front(); checks++;
      if (obs1 !== e) begin failures++; $display("FAIL sat%0d_cmd got %s want %s", k, fmt(obs1), fmt(e)); end
      m1.v = 1'b1; m1.f = 1'b0; m1.pc = 32'h20 * (k + 1);
      m1.cnt = (m1.cnt < 16'd3) ? m1.cnt + 16'd1 : 16'd3;
      q1.push_back(m1);
      tick();
      e = q1.pop_front(); checks++;
      if (obs1 !== e) begin failures++; $display("FAIL sat%0d_load got %s want %s", k, fmt(obs1), fmt(e)); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    rv1 = 1'b1; rc1 = PC_SET; rexe1 = 32'h70;
    m1.v = 1'b0; m1.f = 1'b1;
    q1.push_back(m1);
    tick();
    rv1 = 1'b0;
    e = q1.pop_front(); checks++;
    if (obs1 !== e) begin failures++; $display("FAIL midflush_pre got %s want %s", fmt(obs1), fmt(e)); end
    rst1 = 1'b1;
    m1 = '{v: 1'b0, f: 1'b0, m: 1'b0, pc: 32'h0, cnt: 16'd0};
    q1.push_back(m1);
    #1;
    e = q1.pop_front(); checks++;
    if (obs1 !== e) begin failures++; $display("FAIL midflush_rst got %s want %s", fmt(obs1), fmt(e)); end
    stall0 = 1'b1;
    q0.push_back(m0);
    tick();
    e = q0.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL midstall_pre got %s want %s", fmt(obs0), fmt(e)); end
    rst0 = 1'b1;
    m0 = '{v: 1'b0, f: 1'b0, m: 1'b0, pc: 32'h100, cnt: 16'd0};
    q0.push_back(m0);
    #1;
    e = q0.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL midstall_rst got %s want %s", fmt(obs0), fmt(e)); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_compressed();
    test_cnt_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
